// File: rtl/opcode_pkg.sv
// Shared opcode definitions: two-word opcode nibbles, instruction length predecode
// and the fetch controller state encoding.
package opcode_pkg;

  localparam logic [3:0] OP_JCN = 4'b0001;
  localparam logic [3:0] OP_FIM = 4'b0010;
  localparam logic [3:0] OP_JUN = 4'b0100;
  localparam logic [3:0] OP_JMS = 4'b0101;
  localparam logic [3:0] OP_ISZ = 4'b0111;

  localparam logic [2:0] LEN_ONE = 3'd1;
  localparam logic [2:0] LEN_TWO = 3'd2;

  localparam logic [15:0] STAT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    ISSUE = 2'd3
  } fetch_ctrl_state_t;

  // FIM and SRC share an opcode nibble; bit 0 of the following nibble separates them.
  function automatic logic [2:0] inst_len_f(input logic [3:0] opcode_nibble,
                                            input logic [3:0] next_nibble);
    logic [2:0] len;
    len = LEN_ONE;
    unique case (opcode_nibble)
      OP_JCN, OP_JUN, OP_JMS, OP_ISZ: len = LEN_TWO;
      OP_FIM:  len = next_nibble[0] ? LEN_ONE : LEN_TWO;
      default: len = LEN_ONE;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/fetch_controller.sv
// Fetch sequencer: owns the fetch PC, drives the Fetcher and hands instructions to the decoder.
// Define FETCH_STATS_EN to add saturating stat_issued / stat_squashed counters.
module fetch_controller
  import opcode_pkg::*;
#(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_en,
  output logic        fetch_start,
  output logic [11:0] fetch_pc,
  output logic [2:0]  fetch_inst_len,
  input  logic        fetch_done,
  output logic        fetch_done_ack,
  input  logic [15:0] fetch_inst,
  input  logic [3:0]  rom_nibble,
  output logic        inst_valid,
  output logic [15:0] inst_word,
  output logic [11:0] inst_pc,
  output logic        inst_two_word,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [11:0] redirect_pc,
  output logic [11:0] pc_out,
  output logic        busy
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0] stat_issued,
  output logic [15:0] stat_squashed
`endif
);

  fetch_ctrl_state_t state_q, state_d;
  logic [11:0] pc_q, pc_d;
  logic        squash_q, squash_d;
  logic [15:0] inst_word_q, inst_word_d;
  logic [11:0] inst_pc_q, inst_pc_d;
  logic        inst_two_word_q, inst_two_word_d;

  logic [2:0]  cap_len;
  logic        discard;
  logic        drop;

  // A completed fetch is wrong-path if it was squashed earlier or a redirect lands now.
  assign discard = (state_q == WAIT) && fetch_done && (squash_q || redirect_valid);
  assign drop    = (state_q == ISSUE) && redirect_valid;

  assign cap_len = inst_len_f(fetch_inst[15:12], fetch_inst[11:8]);

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    squash_d        = squash_q;
    inst_word_d     = inst_word_q;
    inst_pc_d       = inst_pc_q;
    inst_two_word_d = inst_two_word_q;
    fetch_start     = 1'b0;
    fetch_done_ack  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (run_en) state_d = START;
      end
      START: begin
        fetch_start = 1'b1;
        state_d     = WAIT;
        if (redirect_valid) squash_d = 1'b1;
      end
      WAIT: begin
        if (fetch_done) begin
          fetch_done_ack = 1'b1;
          if (discard) begin
            squash_d = 1'b0;
            state_d  = run_en ? START : IDLE;
          end else begin
            inst_word_d     = fetch_inst;
            inst_pc_d       = pc_q;
            inst_two_word_d = (cap_len == LEN_TWO);
            pc_d            = pc_q + {9'd0, cap_len};
            state_d         = ISSUE;
          end
        end else if (redirect_valid) begin
          squash_d = 1'b1;
        end
      end
      ISSUE: begin
        if (drop) begin
          state_d = START;
        end else if (inst_ready) begin
          state_d = run_en ? START : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Redirect target wins over any sequential PC advance.
    if (redirect_valid) pc_d = redirect_pc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      pc_q            <= RESET_PC;
      squash_q        <= 1'b0;
      inst_word_q     <= 16'h0000;
      inst_pc_q       <= 12'h000;
      inst_two_word_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      squash_q        <= squash_d;
      inst_word_q     <= inst_word_d;
      inst_pc_q       <= inst_pc_d;
      inst_two_word_q <= inst_two_word_d;
    end
  end

  assign fetch_pc       = (state_q == START) ? pc_q : 12'h000;
  assign fetch_inst_len = inst_len_f(fetch_inst[15:12], rom_nibble);
  assign inst_valid     = (state_q == ISSUE);
  assign inst_word      = inst_word_q;
  assign inst_pc        = inst_pc_q;
  assign inst_two_word  = inst_two_word_q;
  assign pc_out         = pc_q;
  assign busy           = (state_q != IDLE);

`ifdef FETCH_STATS_EN
  logic [15:0] stat_issued_q, stat_issued_d;
  logic [15:0] stat_squashed_q, stat_squashed_d;

  always_comb begin
    stat_issued_d   = stat_issued_q;
    stat_squashed_d = stat_squashed_q;
    if (inst_valid && inst_ready && !redirect_valid && (stat_issued_q != STAT_MAX))
      stat_issued_d = stat_issued_q + 16'd1;
    if ((discard || drop) && (stat_squashed_q != STAT_MAX))
      stat_squashed_d = stat_squashed_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_issued_q   <= 16'h0000;
      stat_squashed_q <= 16'h0000;
    end else begin
      stat_issued_q   <= stat_issued_d;
      stat_squashed_q <= stat_squashed_d;
    end
  end

  assign stat_issued   = stat_issued_q;
  assign stat_squashed = stat_squashed_q;
`endif

endmodule
